// File: rtl/memctrl_pkg.sv
// Shared types, encodings and small helpers for the mem_ctrl block.
// Used by both mem_ctrl and memctrl_byte_seq.
package memctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    // Cycles between presenting a RAM address and its byte appearing on ram_din_i.
    localparam logic [2:0] RAM_RD_LATENCY = 3'd1;
    localparam logic [2:0] N_WORD         = 3'd4;

    function automatic logic [2:0] width_to_n(input logic [1:0] width);
        logic [2:0] n;
        case (width)
            W_BYTE:  n = 3'd1;
            W_HALF:  n = 3'd2;
            W_WORD:  n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] data, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = data[7:0];
            3'd1:    b = data[15:8];
            3'd2:    b = data[23:16];
            3'd3:    b = data[31:24];
            default: b = data[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/memctrl_byte_seq.sv
// Byte sequencer for mem_ctrl: byte counter, latched base/count, next-address
// generation and little-endian assembly of read bytes.
module memctrl_byte_seq
    import memctrl_pkg::*;
#(
    parameter int RAM_AW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RAM_AW-1:0] start_base,
    input  logic [2:0]        start_n,
    input  logic              advance,
    input  logic              capture,
    input  logic [7:0]        din,
    output logic [2:0]        cnt,
    output logic [RAM_AW-1:0] addr_next,
    output logic              more,
    output logic              done,
    output logic [31:0]       word_next
);

    logic [2:0]        cnt_r;
    logic [RAM_AW-1:0] base_r;
    logic [2:0]        n_r;
    logic [31:0]       word_r;
    logic [2:0]        cnt_inc_s;
    logic [2:0]        lane_s;
    logic [31:0]       word_next_s;

    assign cnt_inc_s = cnt_r + 3'd1;
    assign lane_s    = cnt_r - RAM_RD_LATENCY;
    // Address arithmetic wraps silently at 2^RAM_AW.
    assign addr_next = base_r + {{(RAM_AW-3){1'b0}}, cnt_inc_s};
    assign more      = (cnt_inc_s < n_r);
    assign done      = (cnt_r == (n_r + RAM_RD_LATENCY - 3'd1));
    assign cnt       = cnt_r;
    assign word_next = word_next_s;

    // Merge the byte arriving this cycle into the lane of the address that produced it.
    always_comb begin
        word_next_s = word_r;
        if (capture && (cnt_r >= RAM_RD_LATENCY)) begin
            case (lane_s)
                3'd0:    word_next_s[7:0]   = din;
                3'd1:    word_next_s[15:8]  = din;
                3'd2:    word_next_s[23:16] = din;
                3'd3:    word_next_s[31:24] = din;
                default: word_next_s        = word_r;
            endcase
        end else begin
            word_next_s = word_r;
        end
    end

    // Counter, latched request parameters and partially assembled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 3'd0;
            base_r <= '0;
            n_r    <= 3'd0;
            word_r <= 32'd0;
        end else if (start) begin
            cnt_r  <= 3'd0;
            base_r <= start_base;
            n_r    <= start_n;
            word_r <= 32'd0;
        end else begin
            if (advance) begin
                cnt_r <= cnt_inc_s;
            end
            word_r <= word_next_s;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves instruction fetches and MEM-stage loads/stores over one byte-wide RAM port.
// Optional: define MEMCTRL_IF_ABORT_EN to let if_jump_i cancel an in-flight fetch.
module mem_ctrl
    import memctrl_pkg::*;
#(
    parameter int RAM_AW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_jump_i,
    output logic              is_if_output_o,
    output logic              inst_ready_o,
    output logic [31:0]       inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [1:0]        mem_width_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_ready_o,
    output logic [31:0]       mem_rdata_o,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    state_t            state_r, state_next_s;
    logic [RAM_AW-1:0] ram_a_r, ram_a_next_s;
    logic              ram_wr_r, ram_wr_next_s;
    logic [7:0]        ram_dout_r, ram_dout_next_s;
    logic [31:0]       inst_r, inst_next_s;
    logic              inst_ready_r, inst_ready_next_s;
    logic [31:0]       mem_rdata_r, mem_rdata_next_s;
    logic              mem_ready_r, mem_ready_next_s;
    logic [31:0]       wdata_r, wdata_next_s;

    logic              seq_start_s;
    logic              seq_advance_s;
    logic              seq_capture_s;
    logic [RAM_AW-1:0] seq_base_s;
    logic [2:0]        seq_n_s;
    logic [2:0]        seq_cnt_s;
    logic [RAM_AW-1:0] seq_addr_next_s;
    logic              seq_more_s;
    logic              seq_done_s;
    logic [31:0]       seq_word_s;
    logic [2:0]        cnt_inc_s;
    logic              abort_s;

`ifdef MEMCTRL_IF_ABORT_EN
    assign abort_s = (state_r == IF_RD) && if_jump_i;
`else
    logic unused_jump_s;
    assign unused_jump_s = if_jump_i;
    assign abort_s       = 1'b0;
`endif

    assign cnt_inc_s = seq_cnt_s + 3'd1;

    memctrl_byte_seq #(
        .RAM_AW (RAM_AW)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (seq_start_s),
        .start_base (seq_base_s),
        .start_n    (seq_n_s),
        .advance    (seq_advance_s),
        .capture    (seq_capture_s),
        .din        (ram_din_i),
        .cnt        (seq_cnt_s),
        .addr_next  (seq_addr_next_s),
        .more       (seq_more_s),
        .done       (seq_done_s),
        .word_next  (seq_word_s)
    );

    // Next state, arbitration and next values of the output registers.
    always_comb begin
        state_next_s      = state_r;
        ram_a_next_s      = ram_a_r;
        ram_wr_next_s     = 1'b0;
        ram_dout_next_s   = ram_dout_r;
        inst_next_s       = inst_r;
        inst_ready_next_s = 1'b0;
        mem_rdata_next_s  = mem_rdata_r;
        mem_ready_next_s  = 1'b0;
        wdata_next_s      = wdata_r;
        seq_start_s       = 1'b0;
        seq_advance_s     = 1'b0;
        seq_capture_s     = 1'b0;
        seq_base_s        = mem_addr_i[RAM_AW-1:0];
        seq_n_s           = width_to_n(mem_width_i);

        case (state_r)
            IDLE: begin
                // MEM stage wins; the accepted address goes straight onto the RAM port.
                if (mem_req_i) begin
                    seq_start_s  = 1'b1;
                    ram_a_next_s = mem_addr_i[RAM_AW-1:0];
                    if (mem_we_i) begin
                        state_next_s    = MEM_WR;
                        ram_wr_next_s   = 1'b1;
                        ram_dout_next_s = mem_wdata_i[7:0];
                        wdata_next_s    = mem_wdata_i;
                    end else begin
                        state_next_s = MEM_RD;
                    end
                end else if (if_req_i) begin
                    seq_start_s  = 1'b1;
                    seq_base_s   = if_addr_i[RAM_AW-1:0];
                    seq_n_s      = N_WORD;
                    ram_a_next_s = if_addr_i[RAM_AW-1:0];
                    state_next_s = IF_RD;
                end else begin
                    state_next_s = IDLE;
                end
            end

            IF_RD, MEM_RD: begin
                seq_advance_s = 1'b1;
                seq_capture_s = 1'b1;
                if (abort_s) begin
                    state_next_s = IDLE;
                end else if (seq_done_s) begin
                    state_next_s = IDLE;
                    if (state_r == IF_RD) begin
                        inst_next_s       = seq_word_s;
                        inst_ready_next_s = 1'b1;
                    end else begin
                        mem_rdata_next_s = seq_word_s;
                        mem_ready_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = state_r;
                    if (seq_more_s) begin
                        ram_a_next_s = seq_addr_next_s;
                    end else begin
                        ram_a_next_s = ram_a_r;
                    end
                end
            end

            MEM_WR: begin
                seq_advance_s = 1'b1;
                if (seq_more_s) begin
                    ram_wr_next_s   = 1'b1;
                    ram_a_next_s    = seq_addr_next_s;
                    ram_dout_next_s = byte_of(wdata_r, cnt_inc_s);
                end else begin
                    state_next_s     = IDLE;
                    mem_ready_next_s = 1'b1;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ram_a_r      <= '0;
            ram_wr_r     <= 1'b0;
            ram_dout_r   <= 8'd0;
            inst_r       <= 32'd0;
            inst_ready_r <= 1'b0;
            mem_rdata_r  <= 32'd0;
            mem_ready_r  <= 1'b0;
            wdata_r      <= 32'd0;
        end else begin
            state_r      <= state_next_s;
            ram_a_r      <= ram_a_next_s;
            ram_wr_r     <= ram_wr_next_s;
            ram_dout_r   <= ram_dout_next_s;
            inst_r       <= inst_next_s;
            inst_ready_r <= inst_ready_next_s;
            mem_rdata_r  <= mem_rdata_next_s;
            mem_ready_r  <= mem_ready_next_s;
            wdata_r      <= wdata_next_s;
        end
    end

    // Fetch may proceed when the port is its own or would be granted to it now.
    assign is_if_output_o = (state_r == IF_RD) || ((state_r == IDLE) && !mem_req_i);
    assign inst_ready_o   = inst_ready_r;
    assign inst_o         = inst_r;
    assign mem_ready_o    = mem_ready_r;
    assign mem_rdata_o    = mem_rdata_r;
    assign ram_a_o        = ram_a_r;
    assign ram_wr_o       = ram_wr_r;
    assign ram_dout_o     = ram_dout_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, reference memory and
// per-transaction timeline predictions derived from the access rules.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_jump = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [1:0]  mem_width = 2'b00;
    logic [31:0] mem_wdata = 32'd0;
    logic [7:0]  ram_din = 8'd0;
    logic        is_if_output_o;
    logic        inst_ready_o;
    logic [31:0] inst_o;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ram_dut [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl #(.RAM_AW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_jump_i      (if_jump),
        .is_if_output_o (is_if_output_o),
        .inst_ready_o   (inst_ready_o),
        .inst_o         (inst_o),
        .mem_req_i      (mem_req),
        .mem_we_i       (mem_we),
        .mem_addr_i     (mem_addr),
        .mem_width_i    (mem_width),
        .mem_wdata_i    (mem_wdata),
        .mem_ready_o    (mem_ready_o),
        .mem_rdata_o    (mem_rdata_o),
        .ram_a_o        (ram_a_o),
        .ram_wr_o       (ram_wr_o),
        .ram_dout_o     (ram_dout_o),
        .ram_din_i      (ram_din)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        else return init_byte(a);
    endfunction

    function automatic logic [7:0] dut_rd(input logic [31:0] a);
        if (ram_dut.exists(a)) return ram_dut[a];
        else return init_byte(a);
    endfunction

    // Synchronous byte RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_wr_o) ram_dut[ram_a_o] = ram_dout_o;
        ram_din <= dut_rd(ram_a_o);
    end

    task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ram_dut[a + 32'(i)] = w[8*i +: 8];
            ref_mem[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    // kind: 0 = fetch, 1 = load, 2 = store. Starts in the current cycle (caller sits at a negedge).
    task automatic run_xact(input int kind, input logic [31:0] addr, input logic [1:0] width,
                            input logic [31:0] wdata, input bit hold_if, input int jump_cycle);
        int n, exp_r, last_c, k;
        bit rd, aborted, ready_s, other_s, exp_wr;
        logic [31:0] exp_word, exp_a;
        logic [7:0]  b;
        n = (kind == 0) ? 4 : ((width == 2'b00) ? 1 : ((width == 2'b01) ? 2 : 4));
        rd = (kind != 2);
        exp_r = rd ? n + 2 : n + 1;
        aborted = 1'b0;
`ifdef MEMCTRL_IF_ABORT_EN
        aborted = (kind == 0) && (jump_cycle >= 1) && (jump_cycle <= 5);
`endif
        last_c = aborted ? jump_cycle + 1 : exp_r;
        exp_word = 32'd0;
        for (int i = 0; i < n; i++) exp_word[8*i +: 8] = rd ? ref_rd(addr + 32'(i)) : 8'h00;

        if (kind == 0) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = (kind == 2); mem_addr = addr;
            mem_width = width; mem_wdata = wdata; if_req = hold_if;
        end
        if_jump = 1'b0;
        #1;
        n_vec++;
        if (is_if_output_o !== (kind == 0))
            begin n_err++; $display("FAIL is_if_output c0 kind%0d: got %b expected %b", kind, is_if_output_o, kind == 0); end

        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            mem_req = 1'b0; if_req = hold_if; if_jump = (c == jump_cycle);
            #1;
            ready_s = (kind == 0) ? inst_ready_o : mem_ready_o;
            other_s = (kind == 0) ? mem_ready_o : inst_ready_o;
            n_vec++;
            if (ready_s !== ((c == exp_r) && !aborted))
                begin n_err++; $display("FAIL ready kind%0d c%0d: got %b expected %b", kind, c, ready_s, (c == exp_r) && !aborted); end
            n_vec++;
            if (other_s !== 1'b0)
                begin n_err++; $display("FAIL other_ready kind%0d c%0d: got %b expected 0", kind, c, other_s); end
            n_vec++;
            if (is_if_output_o !== ((kind == 0) || (c >= exp_r)))
                begin n_err++; $display("FAIL is_if_output kind%0d c%0d: got %b expected %b", kind, c, is_if_output_o, (kind == 0) || (c >= exp_r)); end
            k = (c <= n) ? c : n;
            if (aborted && k > jump_cycle) k = jump_cycle;
            exp_a = addr + 32'(k - 1);
            n_vec++;
            if (ram_a_o !== exp_a)
                begin n_err++; $display("FAIL ram_a kind%0d c%0d: got %h expected %h", kind, c, ram_a_o, exp_a); end
            exp_wr = (kind == 2) && (c <= n);
            n_vec++;
            if (ram_wr_o !== exp_wr)
                begin n_err++; $display("FAIL ram_wr kind%0d c%0d: got %b expected %b", kind, c, ram_wr_o, exp_wr); end
            if (exp_wr) begin
                n_vec++;
                if (ram_dout_o !== wdata[8*(c-1) +: 8])
                    begin n_err++; $display("FAIL ram_dout c%0d: got %h expected %h", c, ram_dout_o, wdata[8*(c-1) +: 8]); end
            end
            if ((c == exp_r) && !aborted && rd) begin
                n_vec++;
                if (kind == 0 && inst_o !== exp_word)
                    begin n_err++; $display("FAIL inst @%h: got %h expected %h", addr, inst_o, exp_word); end
                else if (kind == 1 && mem_rdata_o !== exp_word)
                    begin n_err++; $display("FAIL mem_rdata @%h w%0d: got %h expected %h", addr, width, mem_rdata_o, exp_word); end
            end
        end

        if (kind == 2) begin
            for (int i = 0; i < n; i++) begin
                b = wdata[8*i +: 8];
                n_vec++;
                if (dut_rd(addr + 32'(i)) !== b)
                    begin n_err++; $display("FAIL ram_content %h: got %h expected %h", addr + 32'(i), dut_rd(addr + 32'(i)), b); end
                ref_mem[addr + 32'(i)] = b;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({inst_ready_o, mem_ready_o, ram_wr_o} !== 3'b000)
            begin n_err++; $display("FAIL reset_strobes: got %b expected 000", {inst_ready_o, mem_ready_o, ram_wr_o}); end
        n_vec++;
        if ({inst_o, mem_rdata_o} !== 64'd0)
            begin n_err++; $display("FAIL reset_data: got %h expected 0", {inst_o, mem_rdata_o}); end
        n_vec++;
        if ({ram_a_o, ram_dout_o} !== 40'd0)
            begin n_err++; $display("FAIL reset_ram_port: got %h expected 0", {ram_a_o, ram_dout_o}); end
        n_vec++;
        if (is_if_output_o !== 1'b1)
            begin n_err++; $display("FAIL reset_is_if_output: got %b expected 1", is_if_output_o); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (is_if_output_o !== 1'b1)
            begin n_err++; $display("FAIL post_reset_is_if_output: got %b expected 1", is_if_output_o); end
        @(negedge clk);
    endtask

    task automatic test_fetch;
        preload_word(32'h0000_1000, 32'h0000_0513);
        run_xact(0, 32'h0000_1000, 2'b10, 32'd0, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_arbitration;
        preload_word(32'h0000_2000, 32'h8765_4321);
        if_addr = 32'h0000_1000;
        run_xact(1, 32'h0000_2000, 2'b10, 32'd0, 1'b1, 0);
        run_xact(0, 32'h0000_1000, 2'b10, 32'd0, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_store_byte;
        run_xact(2, 32'h0003_0004, 2'b00, 32'h0000_00AB, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_half_load;
        ram_dut[32'h0000_2002] = 8'h34; ref_mem[32'h0000_2002] = 8'h34;
        ram_dut[32'h0000_2003] = 8'h12; ref_mem[32'h0000_2003] = 8'h12;
        run_xact(1, 32'h0000_2002, 2'b01, 32'd0, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_jump;
        preload_word(32'h0000_4000, 32'hDEAD_BEEF);
        run_xact(0, 32'h0000_4000, 2'b10, 32'd0, 1'b0, 3);
        run_xact(0, 32'h0000_1000, 2'b10, 32'd0, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        preload_word(32'h0000_5000, 32'h1122_3344);
        preload_word(32'h0000_5004, 32'h5566_7788);
        run_xact(0, 32'h0000_5000, 2'b10, 32'd0, 1'b0, 0);
        run_xact(0, 32'h0000_5004, 2'b10, 32'd0, 1'b0, 0);
        run_xact(0, 32'h0000_1000, 2'b10, 32'd0, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_random;
        int kind, gap;
        logic [31:0] addr;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            if (kind == 0) addr[1:0] = 2'b00;
            run_xact(kind, addr, 2'($urandom_range(0, 3)), $urandom, 1'b0, 0);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store;
        logic [31:0] a;
        a = 32'h0005_0010;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = a; mem_width = 2'b10; mem_wdata = 32'hC3B2_A190;
        #1;
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        n_vec++;
        if (ram_wr_o !== 1'b1 || ram_a_o !== a)
            begin n_err++; $display("FAIL mid_store_c1: got wr=%b a=%h expected wr=1 a=%h", ram_wr_o, ram_a_o, a); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ram_wr_o !== 1'b0)
            begin n_err++; $display("FAIL mid_store_reset_wr: got %b expected 0", ram_wr_o); end
        n_vec++;
        if ({ram_a_o, ram_dout_o, mem_ready_o, inst_ready_o} !== 42'd0)
            begin n_err++; $display("FAIL mid_store_reset_outputs: got %h expected 0", {ram_a_o, ram_dout_o, mem_ready_o, inst_ready_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (is_if_output_o !== 1'b1 || ram_wr_o !== 1'b0)
            begin n_err++; $display("FAIL mid_store_release: got is_if=%b wr=%b expected 1 0", is_if_output_o, ram_wr_o); end
        n_vec++;
        if (dut_rd(a) !== 8'h90)
            begin n_err++; $display("FAIL mid_store_byte0: got %h expected 90", dut_rd(a)); end
        ref_mem[a] = 8'h90;
        for (int i = 1; i < 4; i++) begin
            n_vec++;
            if (dut_rd(a + 32'(i)) !== ref_rd(a + 32'(i)))
                begin n_err++; $display("FAIL mid_store_byte%0d: got %h expected %h", i, dut_rd(a + 32'(i)), ref_rd(a + 32'(i))); end
        end
        @(negedge clk);
        run_xact(0, a, 2'b10, 32'd0, 1'b0, 0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_store_byte();
        test_half_load();
        test_jump();
        test_back_to_back();
        test_random();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Responder side of the instruction-fetch/memory-controller interface. It serves word-fetch requests from the instruction-fetch stage and load/store requests from the MEM stage over a single byte-wide synchronous RAM port. For each request it sequences byte addresses, assembles little-endian words and returns a one-cycle ready pulse. It arbitrates between the two requesters and reports port ownership back to fetch so fetch can decide whether to stall.

## Interface
Parameters:
- `RAM_AW`, 32: RAM address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_req_i`  in  1  fetch requests the word at `if_addr_i`.
- `if_addr_i`  in  32  fetch address, word-aligned.
- `if_jump_i`  in  1  fetch PC was redirected; the current fetch is stale.
- `is_if_output_o`  out  1  RAM port is idle or owned by fetch.
- `inst_ready_o`  out  1  one-cycle pulse: `inst_o` is valid.
- `inst_o`  out  32  fetched instruction word.
- `mem_req_i`  in  1  MEM stage request.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  byte address.
- `mem_width_i`  in  2  00 = byte, 01 = half, 10 = word, 11 = word.
- `mem_wdata_i`  in  32  store data; low bytes are used first.
- `mem_ready_o`  out  1  one-cycle pulse: access done and `mem_rdata_o` valid (loads).
- `mem_rdata_o`  out  32  load data, zero-extended.
- `ram_a_o`  out  RAM_AW  RAM byte address.
- `ram_wr_o`  out  1  RAM write strobe.
- `ram_dout_o`  out  8  RAM write byte.
- `ram_din_i`  in  8  RAM read byte. Valid in the cycle after its address is presented.

## Operation
States:
- `IDLE`, `IF_RD`, `MEM_RD`, `MEM_WR`.
- Byte counter `cnt` is 3 bits. Byte count `n` is 1, 2 or 4, derived from width.

Arbitration (in IDLE only):
- `mem_req_i` has priority over `if_req_i`.
- An in-flight access is never preempted.
- On accept, base address, `n`, and store data are latched; `cnt` is cleared.

Reads (IF_RD, MEM_RD):
- `ram_a_o` = base + `cnt` while `cnt` < `n`.
- The byte returned on `ram_din_i` in the following cycle is placed in byte lane `cnt`−1.
- After the last byte is captured, the ready output pulses with the assembled word and the FSM returns to IDLE.
- Fetches always use `n` = 4.

Writes (MEM_WR):
- `ram_wr_o` = 1 and `ram_dout_o` = byte `cnt` of the store data, at base + `cnt`, for each `cnt` < `n`.
- `mem_ready_o` pulses after the last byte.

Other rules:
- `is_if_output_o` = (state == IF_RD) or (state == IDLE and !`mem_req_i`).
- Address arithmetic is modulo 2^RAM_AW; base + `cnt` wraps with no error.
- `ram_wr_o` is 0 whenever the state is not MEM_WR.
- `ram_a_o` holds its last value when idle.
- Reset (any time, including mid-access):
  - state → IDLE, `cnt` → 0;
  - all outputs → 0, except `is_if_output_o` → 1;
  - a partial write is abandoned with no further bytes written.

## Timing
- The accept edge ends cycle 0.
- Reads:
  - addresses are presented in cycles 1..`n`;
  - ready and data are registered and high in cycle `n`+2;
  - word fetch: `inst_ready_o` in cycle 6.
- Writes:
  - bytes are written in cycles 1..`n`;
  - `mem_ready_o` is high in cycle `n`+1.
- The ready cycle is an IDLE cycle, so a new request can be accepted at the end of it. Back-to-back word fetches complete every 6 cycles.
- `inst_o` and `mem_rdata_o` hold their value until the next ready pulse.
- If `if_req_i` drops mid-fetch, the fetch still completes (unless aborted, see Configuration).

## Configuration
- `MEMCTRL_IF_ABORT_EN` defined:
  - `if_jump_i` high during IF_RD forces IDLE on the next edge;
  - no `inst_ready_o` pulse is issued for the aborted fetch;
  - arbitration resumes in the following cycle.
- `MEMCTRL_IF_ABORT_EN` undefined:
  - `if_jump_i` is ignored;
  - a stale fetch completes and pulses `inst_ready_o`, and the consumer discards it.

## Structure
- Shared package `memctrl_pkg`:
  - state enum;
  - width encodings (`W_BYTE`, `W_HALF`, `W_WORD`);
  - `RAM_RD_LATENCY` = 1.
- One sub-module, `memctrl_byte_seq`:
  - owns `cnt`, base-address increment, byte-lane assembly and the done flag;
  - the top level holds the FSM, arbitration and output registers.

## Test plan
- Fetch at 0x1000 with RAM bytes 13 05 00 00 → addresses 0x1000..0x1003 in cycles 1–4, `inst_ready_o` pulse in cycle 6, `inst_o` = 0x00000513.
- `if_req_i` and `mem_req_i` (load word at 0x2000) raised together → MEM served first, `is_if_output_o` = 0 until `mem_ready_o`, fetch accepted in the ready cycle.
- Store byte 0xAB at 0x30004 → one cycle with `ram_wr_o` = 1, `ram_a_o` = 0x30004, `ram_dout_o` = 0xAB; `mem_ready_o` in cycle 2.
- Halfword load at 0x2002 with bytes 34 12 → `mem_rdata_o` = 0x00001234 with `mem_ready_o` in cycle 4.
- `if_jump_i` in cycle 3 of a fetch → with the macro: no pulse, IDLE next cycle, new fetch completes normally; without the macro: old word still pulses in cycle 6.
- `rst_n` low in cycle 2 of a word store → `ram_wr_o` = 0 immediately, only byte 0 written; after release the block is IDLE with `is_if_output_o` = 1.
